// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field request and encoded-word handshake bundle for instr_encoder
interface instr_encoder_if #(
   parameter int ADDR_W = 12
);
   logic              i_valid;
   logic              o_ready;
   logic [6:0]        i_opcode;
   logic [4:0]        i_rd;
   logic [4:0]        i_rs1;
   logic [4:0]        i_rs2;
   logic [2:0]        i_funct3;
   logic [6:0]        i_funct7;
   logic [31:0]       i_imm;
   logic              o_valid;
   logic              i_ready;
   logic [31:0]       o_instr;
   logic [ADDR_W-1:0] o_addr;
   logic              o_err;
   logic              o_err_any;
   modport slave (
      input  i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
      output o_ready, o_valid, o_instr, o_addr, o_err, o_err_any
   );
   modport master (
      output i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
      input  o_ready, o_valid, o_instr, o_addr, o_err, o_err_any
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into a word through a 2-stage elastic pipeline
// with immediate range checking and a wrapping byte-address counter.
module instr_encoder #(
   parameter int                ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic            i_clk,
   input logic            i_rst,
   input logic            i_clear,
   instr_encoder_if.slave bus
);
   localparam logic [6:0]  OP_R = 7'b0110011;
   localparam logic [6:0]  OP_I = 7'b0010011;
   localparam logic [6:0]  OP_S = 7'b0100011;
   localparam logic [6:0]  OP_B = 7'b1100011;
   localparam logic [6:0]  OP_U = 7'b0110111;
   localparam logic [6:0]  OP_J = 7'b1101111;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic              r_a_valid, r_a_err;
   logic [6:0]        r_a_op, r_a_f7;
   logic [4:0]        r_a_rd, r_a_rs1, r_a_rs2;
   logic [2:0]        r_a_f3;
   logic [31:0]       r_a_imm;
   logic              r_b_valid, r_b_err, r_err_any;
   logic [31:0]       r_b_instr;
   logic [ADDR_W-1:0] r_addr;

   logic        w_sx11, w_sx12, w_sx20, w_in_err;
   logic        w_a_take, w_b_take, w_out_fire;
   logic [31:0] w_word;

   // Sign-extension checks: the bits above the format's top bit must replicate it
   assign w_sx11 = &bus.i_imm[31:11] | ~|bus.i_imm[31:11];
   assign w_sx12 = &bus.i_imm[31:12] | ~|bus.i_imm[31:12];
   assign w_sx20 = &bus.i_imm[31:20] | ~|bus.i_imm[31:20];

   always_comb begin
      w_in_err = (bus.i_opcode == OP_I || bus.i_opcode == OP_S) ? !w_sx11 :
                 (bus.i_opcode == OP_B) ? (bus.i_imm[0] | !w_sx12) :
                 (bus.i_opcode == OP_J) ? (bus.i_imm[0] | !w_sx20) :
                 (bus.i_opcode == OP_U) ? |bus.i_imm[11:0] :
                 (bus.i_opcode != OP_R);
   end

   always_comb begin
      w_word = r_a_err ? NOP :
               (r_a_op == OP_R) ? {r_a_f7, r_a_rs2, r_a_rs1, r_a_f3, r_a_rd, r_a_op} :
               (r_a_op == OP_I) ? {r_a_imm[11:0], r_a_rs1, r_a_f3, r_a_rd, r_a_op} :
               (r_a_op == OP_S) ? {r_a_imm[11:5], r_a_rs2, r_a_rs1, r_a_f3, r_a_imm[4:0], r_a_op} :
               (r_a_op == OP_B) ? {r_a_imm[12], r_a_imm[10:5], r_a_rs2, r_a_rs1, r_a_f3,
                                   r_a_imm[4:1], r_a_imm[11], r_a_op} :
               (r_a_op == OP_U) ? {r_a_imm[31:12], r_a_rd, r_a_op} :
               {r_a_imm[20], r_a_imm[10:1], r_a_imm[11], r_a_imm[19:12], r_a_rd, r_a_op};
   end

   assign w_b_take   = !r_b_valid || bus.i_ready;
   assign w_a_take   = !r_a_valid || w_b_take;
   assign w_out_fire = r_b_valid && bus.i_ready;

   assign bus.o_ready   = w_a_take;
   assign bus.o_valid   = r_b_valid;
   assign bus.o_instr   = r_b_instr;
   assign bus.o_err     = r_b_err;
   assign bus.o_addr    = r_addr;
   assign bus.o_err_any = r_err_any;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_a_valid <= 1'b0;
         r_b_valid <= 1'b0;
         r_b_instr <= '0;
         r_b_err   <= 1'b0;
         r_err_any <= 1'b0;
         r_addr    <= BASE_ADDR;
      end else begin
         if (w_a_take) begin
            r_a_valid <= bus.i_valid;
            r_a_op    <= bus.i_opcode;
            r_a_rd    <= bus.i_rd;
            r_a_rs1   <= bus.i_rs1;
            r_a_rs2   <= bus.i_rs2;
            r_a_f3    <= bus.i_funct3;
            r_a_f7    <= bus.i_funct7;
            r_a_imm   <= bus.i_imm;
            r_a_err   <= w_in_err;
         end
         if (w_b_take) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
               r_b_instr <= w_word;
               r_b_err   <= r_a_err;
            end
         end
         if (w_out_fire) begin
            r_addr    <= r_addr + ADDR_W'(4);
            r_err_any <= r_err_any | r_b_err;
         end
      end
   end
endmodule
